// File: rtl/long_mul_add_u16_by_u8.sv
// Sequential radix-16 multiply-add: out_data = in_a * in_b + in_c (u16 x u8 + u8 -> u24).
// Optional zero-operand shortcut enabled by defining SNOW64_LONG_MUL_ADD_ZERO_SKIP_EN.
module long_mul_add_u16_by_u8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_c,
  output logic        out_data_valid,
  output logic        out_can_accept_cmd,
  output logic [23:0] out_data
);

  typedef enum logic [1:0] {
    StIdle,
    StStarting,
    StWorking
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  c_q, c_d;
  logic [11:0] mult_q [16];
  logic [11:0] mult_d [16];
  logic [23:0] acc_q, acc_d;
  logic [1:0]  i_q, i_d;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        can_q, can_d;

  logic [3:0]  nib;
  logic [23:0] acc_step;

  always_comb begin
    nib = 4'h0;
    case (i_q)
      2'd3:    nib = a_q[15:12];
      2'd2:    nib = a_q[11:8];
      2'd1:    nib = a_q[7:4];
      default: nib = a_q[3:0];
    endcase
  end

  // Shift-in of the next nibble partial product; acc never exceeds 24 bits.
  assign acc_step = {acc_q[19:0], 4'h0} + {12'h000, mult_q[nib]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    i_d     = i_q;
    data_d  = data_q;
    valid_d = valid_q;
    can_d   = can_q;

    case (state_q)
      StIdle: begin
        if (in_start) begin
`ifdef SNOW64_LONG_MUL_ADD_ZERO_SKIP_EN
          if ((in_a == 16'h0000) || (in_b == 8'h00)) begin
            data_d  = {16'h0000, in_c};
            valid_d = 1'b1;
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            c_d     = in_c;
            valid_d = 1'b0;
            can_d   = 1'b0;
            state_d = StStarting;
          end
`else
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          valid_d = 1'b0;
          can_d   = 1'b0;
          state_d = StStarting;
`endif
        end
      end

      StStarting: begin
        for (int unsigned k = 0; k < 16; k++) begin
          mult_d[k] = 12'(b_q) * 12'(k);
        end
        acc_d   = '0;
        i_d     = 2'd3;
        state_d = StWorking;
      end

      StWorking: begin
        acc_d = acc_step;
        i_d   = i_q - 2'd1;
        if (i_q == 2'd0) begin
          data_d  = acc_step + {16'h0000, c_q};
          valid_d = 1'b1;
          can_d   = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        can_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      for (int unsigned k = 0; k < 16; k++) begin
        mult_q[k] <= '0;
      end
      acc_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      can_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      can_q   <= can_d;
    end
  end

  assign out_data           = data_q;
  assign out_data_valid     = valid_q;
  assign out_can_accept_cmd = can_q;

endmodule

// File: doc/long_mul_add_u16_by_u8.md
# long_mul_add_u16_by_u8

Sequential radix-16 multiply-add unit that computes `out_data = in_a * in_b + in_c`. Operand widths are u16 × u8 + u8, and the result is u24. It is the inverse companion of the u16-by-u8 long divider: it rebuilds a dividend from quotient, divisor and remainder. It uses the same start/valid/can-accept command handshake as the divider, so the same issuing logic drives either unit. It sits beside the divider in the snow64 scalar arithmetic path and is shared by the vector lanes.

## Interface
- No parameters. Widths are fixed: in_a 16, in_b 8, in_c 8, out_data 24. Radix 16, 4 bits per iteration, 4 iterations.
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_start  input  1  command strobe; sampled only when out_can_accept_cmd=1.
- in_a  input  16  multiplicand (e.g. quotient).
- in_b  input  8  multiplier (e.g. divisor).
- in_c  input  8  addend (e.g. remainder).
- out_data_valid  output  1  result valid; held until the next accepted command.
- out_can_accept_cmd  output  1  unit idle and ready to accept in_start.
- out_data  output  24  result a*b+c.

## Operation
- States: StIdle, StStarting, StWorking.
- StIdle with in_start=1:
  - Capture in_a, in_b, in_c.
  - Drive out_data_valid<=0 and out_can_accept_cmd<=0.
  - Go to StStarting.
- StStarting:
  - Build the 16-entry table mult[k] = captured_b*k, k=0..15. Each entry is 12 bits.
  - Clear the 24-bit accumulator acc<=0.
  - Set i<=3 (nibble index).
  - Go to StWorking.
- StWorking, one nibble per cycle, MSB first:
  - nib = captured_a[4i+3:4i].
  - acc <= (acc<<4) + mult[nib].
  - i <= i-1.
- StWorking with i==0:
  - out_data <= ((acc<<4) + mult[nib]) + captured_c.
  - out_data_valid<=1, out_can_accept_cmd<=1.
  - Go to StIdle.
- Arithmetic is unsigned and must never lose bits. The maximum result is 0xFFFF*0xFF+0xFF = 0xFF0000, which fits in 24 bits, so there is no overflow flag. Intermediate acc is held at 24 bits.
- in_start while busy (out_can_accept_cmd=0) is ignored. Operand inputs are don't-care outside the accept cycle.
- out_data and out_data_valid hold their value in StIdle until the next accepted in_start. That accept drops out_data_valid on the same edge; out_data keeps its old value until overwritten.
- The unrecognised-state default returns to StIdle.

## Timing
- Reset values (asserted asynchronously, takes effect immediately):
  - state=StIdle.
  - out_data_valid=0.
  - out_can_accept_cmd=1.
  - out_data=0.
  - i, acc and the table are cleared.
- Latency: in_start sampled at edge E0 → StStarting at E1 → StWorking at E2..E5 → out_data_valid=1 and out_data final after E5. That is 6 clock edges from the sampling edge.
- Throughput: a new in_start can be accepted at E6, on the cycle valid is first seen. Back-to-back issue gives one result per 6 cycles.
- Reset mid-operation (any state): abort immediately to reset values. No stale valid is produced after reset release.
- in_start held high continuously: the unit re-accepts on every edge where out_can_accept_cmd=1. Each such accept clears out_data_valid on that same edge.

## Configuration
- Macro: `SNOW64_LONG_MUL_ADD_ZERO_SKIP_EN`.
- Defined: if in_a==0 or in_b==0 at accept, stay in StIdle and take one edge instead of six:
  - out_data <= in_c.
  - out_data_valid <= 1.
  - out_can_accept_cmd stays 1.
- Not defined: zero operands take the full 6-edge path with an identical numeric result.

## Test plan
- Reset check: assert rst mid-StWorking during a 0x1234*0x56+0x78 operation. Outputs go immediately to valid=0, can_accept=1, data=0; after release, no valid pulse appears.
- Basic: a=0x1234, b=0x56, c=0x78 → out_data=0x061DF0, valid exactly 6 edges after the accept edge.
- Max: a=0xFFFF, b=0xFF, c=0xFF → out_data=0xFF0000.
- Divider round trip: a=142, b=7, c=6 → out_data=0x0003E8 (1000).
- Busy ignore and back-to-back:
  - Pulse in_start with a=1, b=1, c=0 at E3 of a 0x1234*0x56+0x78 operation; it is ignored and the result is still 0x061DF0.
  - Then issue a=2, b=3, c=1 on the valid cycle → 0x000007.
- Zero operand: a=0, b=0x55, c=0x11 → out_data=0x000011. Valid after 1 edge with the macro defined, 6 edges without.
